axi_wr_slave_mem_bridge: RTL and testbench

- AXI4 write-channel responder: accepts AW/W bursts from an AXI write master and retires each beat onto a simple synchronous SRAM write port.
- Returns one B response per burst.
- Serves as the memory-side end of the team's AXI write paths, used as a behavioural/on-chip target for write masters.
- Handles one outstanding burst at a time.

---
 rtl/axi_wr_slave_mem_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_wr_slave_mem_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave_mem_bridge.sv
// AXI4 write-channel responder that retires each accepted write beat onto a
// synchronous SRAM write port and returns one B response per burst.
// A single burst is in flight at a time: IDLE -> DATA (-> DRAIN) -> RESP.
module axi_wr_slave_mem_bridge #(
  parameter int ASIZE      = 32,
  parameter int DSIZE      = 64,
  parameter int IDSIZE     = 4,
  parameter int LSIZE      = 8,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [IDSIZE-1:0]     s_awid,
  input  logic [ASIZE-1:0]      s_awaddr,
  input  logic [LSIZE-1:0]      s_awlen,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DSIZE-1:0]      s_wdata,
  input  logic [DSIZE/8-1:0]    s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [IDSIZE-1:0]     s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic                  mem_wen,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [DSIZE-1:0]      mem_wdata,
  output logic [DSIZE/8-1:0]    mem_wstrb
);

  localparam int ADDR_LSB = $clog2(DSIZE / 8);
  localparam int SUMW     = ASIZE + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic                  awready_r;
  logic                  wready_r;
  logic                  bvalid_r;
  logic [IDSIZE-1:0]     bid_r;
  logic [1:0]            bresp_r;

  logic [IDSIZE-1:0]     id_r;
  logic [LSIZE-1:0]      len_r;
  logic [MEM_AWIDTH-1:0] ptr_r;
  logic [LSIZE-1:0]      beat_cnt_r;
  logic [1:0]            err_r;
  logic [1:0]            err_nxt_s;

  logic                  mem_wen_r;
  logic [MEM_AWIDTH-1:0] mem_addr_r;
  logic [DSIZE-1:0]      mem_wdata_r;
  logic [DSIZE/8-1:0]    mem_wstrb_r;

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  b_hs_s;
  logic                  mem_beat_s;
  logic                  last_beat_s;
  logic [ASIZE-1:0]      aw_word_s;
  logic [SUMW-1:0]       aw_end_s;
  logic                  aw_decerr_s;
  logic [1:0]            aw_err_s;

  assign aw_hs_s     = s_awvalid & awready_r;
  assign w_hs_s      = s_wvalid & wready_r;
  assign b_hs_s      = bvalid_r & s_bready;
  assign last_beat_s = (beat_cnt_r == len_r);
  assign mem_beat_s  = (state_r == DATA) & w_hs_s & (err_r == RESP_OKAY);

  // The end word of the burst is computed one bit wider so a wrap past the top
  // of the address space also lands in the out-of-range check.
  assign aw_word_s   = s_awaddr >> ADDR_LSB;
  assign aw_end_s    = {1'b0, aw_word_s} + {{(SUMW - LSIZE){1'b0}}, s_awlen};
  assign aw_decerr_s = |(aw_end_s >> MEM_AWIDTH);
  assign aw_err_s    = aw_decerr_s ? RESP_DECERR :
                       ((s_awburst != BURST_INCR) ? RESP_SLVERR : RESP_OKAY);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and burst error-code update.
  always_comb begin
    next_state_s = state_r;
    err_nxt_s    = err_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) begin
          next_state_s = DATA;
          err_nxt_s    = aw_err_s;
        end else begin
          next_state_s = IDLE;
        end
      end
      DATA: begin
        if (w_hs_s) begin
          if (s_wlast) begin
            next_state_s = RESP;
            if (!last_beat_s && (err_r != RESP_DECERR)) begin
              err_nxt_s = RESP_SLVERR;
            end else begin
              err_nxt_s = err_r;
            end
          end else if (last_beat_s) begin
            next_state_s = DRAIN;
            if (err_r != RESP_DECERR) begin
              err_nxt_s = RESP_SLVERR;
            end else begin
              err_nxt_s = err_r;
            end
          end else begin
            next_state_s = DATA;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      DRAIN: begin
        if (w_hs_s && s_wlast) begin
          next_state_s = RESP;
        end else begin
          next_state_s = DRAIN;
        end
      end
      RESP: begin
        if (b_hs_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s = IDLE;
        err_nxt_s    = RESP_OKAY;
      end
    endcase
  end

  // Handshake and response outputs, registered from the upcoming state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {IDSIZE{1'b0}};
      bresp_r   <= 2'b00;
    end else begin
      awready_r <= (state_r == IDLE) & ~aw_hs_s;
      wready_r  <= (next_state_s == DATA) | (next_state_s == DRAIN);
      bvalid_r  <= (next_state_s == RESP);
      if ((next_state_s == RESP) && (state_r != RESP)) begin
        bid_r   <= id_r;
        bresp_r <= err_nxt_s;
      end
    end
  end

  // Burst context: ID, length, word pointer, beat counter and error code.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      id_r       <= {IDSIZE{1'b0}};
      len_r      <= {LSIZE{1'b0}};
      ptr_r      <= {MEM_AWIDTH{1'b0}};
      beat_cnt_r <= {LSIZE{1'b0}};
      err_r      <= RESP_OKAY;
    end else begin
      err_r <= err_nxt_s;
      if (aw_hs_s) begin
        id_r       <= s_awid;
        len_r      <= s_awlen;
        ptr_r      <= aw_word_s[MEM_AWIDTH-1:0];
        beat_cnt_r <= {LSIZE{1'b0}};
      end else if (w_hs_s && (state_r == DATA)) begin
        ptr_r      <= ptr_r + MEM_AWIDTH'(1);
        beat_cnt_r <= beat_cnt_r + LSIZE'(1);
      end
    end
  end

  // Memory write port: one registered write per qualifying data beat.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= {MEM_AWIDTH{1'b0}};
      mem_wdata_r <= {DSIZE{1'b0}};
      mem_wstrb_r <= {(DSIZE/8){1'b0}};
    end else begin
      mem_wen_r <= mem_beat_s;
      if (mem_beat_s) begin
        mem_addr_r  <= ptr_r;
        mem_wdata_r <= s_wdata;
        mem_wstrb_r <= s_wstrb;
      end
    end
  end

  assign s_awready = awready_r;
  assign s_wready  = wready_r;
  assign s_bvalid  = bvalid_r;
  assign s_bid     = bid_r;
  assign s_bresp   = bresp_r;
  assign mem_wen   = mem_wen_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_axi_wr_slave_mem_bridge.sv
// Bench for axi_wr_slave_mem_bridge: directed and random bursts, with a
// transaction-level reference model compared against the outputs every cycle.
module tb_axi_wr_slave_mem_bridge;

  localparam int ASIZE = 32, DSIZE = 64, IDSIZE = 4, LSIZE = 8, MAW = 12;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [IDSIZE-1:0] s_awid;
  logic [ASIZE-1:0]  s_awaddr;
  logic [LSIZE-1:0]  s_awlen;
  logic [1:0]        s_awburst;
  logic              s_awvalid;
  logic              s_awready;
  logic [DSIZE-1:0]  s_wdata;
  logic [7:0]        s_wstrb;
  logic              s_wlast;
  logic              s_wvalid;
  logic              s_wready;
  logic [IDSIZE-1:0] s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic              mem_wen;
  logic [MAW-1:0]    mem_addr;
  logic [DSIZE-1:0]  mem_wdata;
  logic [7:0]        mem_wstrb;

  axi_wr_slave_mem_bridge #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .IDSIZE(IDSIZE), .LSIZE(LSIZE), .MEM_AWIDTH(MAW)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: burst-level view of what the responder owes the master.
  bit             m_live = 1'b0;
  bit             m_open, m_resp, m_drop;
  int             m_age, m_beat, m_len;
  longint         m_word;
  logic [3:0]     m_id;
  logic [1:0]     m_err;
  bit             e_rst, e_awready, e_wready, e_bvalid, e_wen;
  logic [MAW-1:0] e_addr;
  logic [63:0]    e_data;
  logic [7:0]     e_strb;
  logic [3:0]     e_bid;
  logic [1:0]     e_bresp;

  // Observations used by the directed literal checks.
  int             obs_wen = 0, obs_b = 0;
  logic [MAW-1:0] obs_addr;
  logic [63:0]    obs_data;
  logic [3:0]     obs_bid;
  logic [1:0]     obs_bresp;

  // Compare outputs against the model, then advance the model by one clock edge.
  always @(negedge clock) begin : mon
    bit aw_hs, w_hs, b_hs;
    if (m_live) begin
      chk("awready", 64'(s_awready), 64'(e_awready));
      chk("wready",  64'(s_wready),  64'(e_wready));
      chk("bvalid",  64'(s_bvalid),  64'(e_bvalid));
      chk("mem_wen", 64'(mem_wen),   64'(e_wen));
      if (e_bvalid) begin
        chk("bid",   64'(s_bid),   64'(e_bid));
        chk("bresp", 64'(s_bresp), 64'(e_bresp));
      end
      if (e_wen) begin
        chk("mem_addr",  64'(mem_addr),  64'(e_addr));
        chk("mem_wdata", mem_wdata,      e_data);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(e_strb));
      end
      if (e_rst) begin
        chk("rst_bid",   64'(s_bid),     64'd0);
        chk("rst_bresp", 64'(s_bresp),   64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_wdata", mem_wdata,      64'd0);
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
      end
      if (mem_wen === 1'b1) begin
        obs_wen++;
        obs_addr = mem_addr;
        obs_data = mem_wdata;
      end
      if (s_bvalid === 1'b1 && s_bready === 1'b1) begin
        obs_b++;
        obs_bid   = s_bid;
        obs_bresp = s_bresp;
      end
    end
    if (rst_n === 1'b0) begin
      m_live = 1'b1; m_open = 1'b0; m_resp = 1'b0; m_drop = 1'b0; m_age = 0;
      e_rst = 1'b1; e_awready = 1'b0; e_wready = 1'b0; e_bvalid = 1'b0; e_wen = 1'b0;
    end else if (m_live) begin
      e_rst = 1'b0;
      e_wen = 1'b0;
      aw_hs = s_awvalid && e_awready;
      w_hs  = s_wvalid && e_wready;
      b_hs  = s_bready && e_bvalid;
      if (b_hs) begin
        m_resp = 1'b0;
        m_age  = 0;
      end else if (aw_hs) begin
        m_open = 1'b1; m_drop = 1'b0; m_beat = 0;
        m_id   = s_awid;
        m_len  = int'(s_awlen);
        m_word = longint'(s_awaddr >> 3);
        if (m_word + m_len >= 4096) m_err = 2'b11;
        else if (s_awburst != 2'b01) m_err = 2'b10;
        else m_err = 2'b00;
      end else if (!m_open && !m_resp && m_age < 2) begin
        m_age++;
      end
      if (w_hs) begin
        if (!m_drop) begin
          if (m_err == 2'b00) begin
            e_wen  = 1'b1;
            e_addr = MAW'(m_word + m_beat);
            e_data = s_wdata;
            e_strb = s_wstrb;
          end
          if (s_wlast) begin
            if (m_beat < m_len && m_err != 2'b11) m_err = 2'b10;
            m_open = 1'b0;
            m_resp = 1'b1;
          end else if (m_beat == m_len) begin
            m_drop = 1'b1;
            if (m_err != 2'b11) m_err = 2'b10;
          end
        end else if (s_wlast) begin
          m_open = 1'b0;
          m_resp = 1'b1;
        end
        m_beat++;
      end
      e_awready = !m_open && !m_resp && (m_age >= 1);
      e_wready  = m_open;
      e_bvalid  = m_resp;
      e_bid     = m_id;
      e_bresp   = m_err;
    end
  end

  // which: 0 awready, 1 wready, 2 bvalid&bready, 3 bvalid
  task automatic wait_ready(input int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clock);
      if ((which == 0 && s_awready === 1'b1) || (which == 1 && s_wready === 1'b1) ||
          (which == 2 && s_bvalid === 1'b1 && s_bready === 1'b1) ||
          (which == 3 && s_bvalid === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout waiting on handshake %0d at %0t", which, $time);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bt,
                       input logic [3:0] id, input int nbeats, input int gap, input int bdelay,
                       input logic [63:0] d0, input logic [7:0] s0);
    bit ok;
    int g;
    s_awaddr = addr; s_awlen = len; s_awburst = bt; s_awid = id; s_awvalid = 1'b1;
    wait_ready(0, ok);
    s_awvalid = 1'b0;
    if (!ok) return;
    for (int b = 0; b < nbeats; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (b > 0) begin
        repeat (g) begin
          s_wvalid = 1'b0;
          @(posedge clock);
          #1;
        end
      end
      s_wdata  = (b == 0) ? d0 : {$urandom(), $urandom()};
      s_wstrb  = (b == 0) ? s0 : 8'($urandom_range(0, 255));
      s_wlast  = (b == nbeats - 1);
      s_wvalid = 1'b1;
      wait_ready(1, ok);
      if (!ok) begin
        s_wvalid = 1'b0;
        return;
      end
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    wait_ready(3, ok);
    if (!ok) return;
    repeat (bdelay) begin
      @(posedge clock);
      #1;
    end
    s_bready = 1'b1;
    wait_ready(2, ok);
    s_bready = 1'b0;
  endtask

  int w0, b0;

  task automatic snap();
    w0 = obs_wen;
    b0 = obs_b;
  endtask

  // Safety net in case a bounded wait is ever bypassed.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    int nb, q;
    rst_n = 1'b0; s_awid = 4'd0; s_awaddr = 32'd0; s_awlen = 8'd0; s_awburst = 2'b01;
    s_awvalid = 1'b0; s_wdata = 64'd0; s_wstrb = 8'd0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clock); #1; end

    // Single beat.
    snap();
    burst(32'h10, 8'd0, 2'b01, 4'd3, 1, 0, 0, 64'hA5A5, 8'hFF);
    chk("t1_wen_cnt", 64'(obs_wen - w0), 64'd1);
    chk("t1_addr",    64'(obs_addr),     64'd2);
    chk("t1_data",    obs_data,          64'hA5A5);
    chk("t1_bid",     64'(obs_bid),      64'd3);
    chk("t1_bresp",   64'(obs_bresp),    64'd0);

    // Four beats with wvalid toggling.
    snap();
    burst(32'h100, 8'd3, 2'b01, 4'd5, 4, 1, 0, {$urandom(), $urandom()}, 8'hF0);
    chk("t2_wen_cnt", 64'(obs_wen - w0), 64'd4);
    chk("t2_last_addr", 64'(obs_addr),   64'h23);
    chk("t2_bresp",   64'(obs_bresp),    64'd0);

    // Early last.
    snap();
    burst(32'h400, 8'd3, 2'b01, 4'd7, 2, 0, 1, {$urandom(), $urandom()}, 8'h0F);
    chk("t3_wen_cnt", 64'(obs_wen - w0), 64'd2);
    chk("t3_bresp",   64'(obs_bresp),    64'd2);
    snap();
    burst(32'h408, 8'd1, 2'b01, 4'd8, 2, 0, 0, {$urandom(), $urandom()}, 8'hFF);
    chk("t3_next_bresp", 64'(obs_bresp), 64'd0);
    chk("t3_next_wen",   64'(obs_wen - w0), 64'd2);

    // Late last.
    snap();
    burst(32'h800, 8'd1, 2'b01, 4'd9, 4, 0, 0, {$urandom(), $urandom()}, 8'hFF);
    chk("t4_wen_cnt", 64'(obs_wen - w0), 64'd2);
    chk("t4_bresp",   64'(obs_bresp),    64'd2);

    // Out of range and unsupported burst type.
    snap();
    burst(32'(4094 * 8), 8'd3, 2'b01, 4'd1, 4, 0, 0, {$urandom(), $urandom()}, 8'hFF);
    chk("t5_wen_cnt", 64'(obs_wen - w0), 64'd0);
    chk("t5_bresp",   64'(obs_bresp),    64'd3);
    snap();
    burst(32'h40, 8'd1, 2'b00, 4'd2, 2, 0, 0, {$urandom(), $urandom()}, 8'hFF);
    chk("t5_fixed_wen", 64'(obs_wen - w0), 64'd0);
    chk("t5_fixed_bresp", 64'(obs_bresp),  64'd2);

    // Top-of-memory boundary with the longest burst.
    snap();
    burst(32'(3840 * 8), 8'd255, 2'b01, 4'd4, 256, 0, 0, {$urandom(), $urandom()}, 8'hFF);
    chk("t5_edge_wen",  64'(obs_wen - w0), 64'd256);
    chk("t5_edge_addr", 64'(obs_addr),     64'd4095);
    chk("t5_edge_bresp", 64'(obs_bresp),   64'd0);
    snap();
    burst(32'(3841 * 8), 8'd255, 2'b01, 4'd4, 256, 0, 0, {$urandom(), $urandom()}, 8'hFF);
    chk("t5_over_bresp", 64'(obs_bresp),   64'd3);

    // Response backpressure.
    snap();
    burst(32'h200, 8'd2, 2'b01, 4'd12, 3, 0, 10, {$urandom(), $urandom()}, 8'hFF);
    chk("t6_bid", 64'(obs_bid), 64'd12);

    // Reset in the middle of a data phase.
    snap();
    s_awaddr = 32'h300; s_awlen = 8'd3; s_awburst = 2'b01; s_awid = 4'd6; s_awvalid = 1'b1;
    wait_ready(0, ok);
    s_awvalid = 1'b0;
    s_wdata = 64'h1234; s_wstrb = 8'hFF; s_wlast = 1'b0; s_wvalid = 1'b1;
    wait_ready(1, ok);
    s_wdata = 64'h5678;
    rst_n = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
    s_wvalid = 1'b0;
    s_bready = 1'b1;
    repeat (6) begin @(posedge clock); #1; end
    s_bready = 1'b0;
    chk("t7_no_b", 64'(obs_b - b0), 64'd0);
    chk("t7_wen_cnt", 64'(obs_wen - w0), 64'd1);

    // Randomized bursts.
    for (int i = 0; i < 60; i++) begin
      q  = int'($urandom_range(0, 9));
      ra = (q == 0) ? $urandom() : ((32'($urandom_range(0, 4095)) << 3) | 32'($urandom_range(0, 7)));
      rl = (q == 1) ? 8'($urandom_range(8, 40)) : 8'($urandom_range(0, 7));
      rb = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      q  = int'($urandom_range(0, 5));
      if (q == 0) nb = int'($urandom_range(1, int'(rl) + 1));
      else if (q == 1) nb = int'(rl) + 1 + int'($urandom_range(1, 3));
      else nb = int'(rl) + 1;
      burst(ra, rl, rb, 4'($urandom_range(0, 15)), nb, -1, int'($urandom_range(0, 3)),
            {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
    end

    repeat (4) begin @(posedge clock); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
